// File: rtl/rps_round_controller.sv
// Rock-paper-scissors round sequencer: latches the user move, predicts a counter-move from
// learned move frequencies, drives two sprite draws over a req/done handshake, then scores.
module rps_round_controller #(
    parameter int unsigned SCORE_W   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic [1:0]         user_choice,
    input  logic               draw_done,
    output logic               draw_req,
    output logic               draw_player,
    output logic [1:0]         draw_choice,
    output logic [1:0]         comp_choice,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] comp_score,
    output logic               busy
);

    localparam logic [1:0] MV_ROCK    = 2'b00;
    localparam logic [1:0] MV_SCISSOR = 2'b01;
    localparam logic [1:0] MV_PAPER   = 2'b10;
    localparam logic [1:0] MV_INVALID = 2'b11;

    localparam logic [1:0] RES_TIE  = 2'b00;
    localparam logic [1:0] RES_USER = 2'b01;
    localparam logic [1:0] RES_COMP = 2'b10;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_DRAW_U,
        S_GAP,
        S_DRAW_C,
        S_SCORE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]         user_move, user_move_nxt;
    logic [CNT_W-1:0]   cnt_rock, cnt_scissor, cnt_paper;
    logic [CNT_W-1:0]   cnt_rock_nxt, cnt_scissor_nxt, cnt_paper_nxt;
    logic [CNT_W-1:0]   cnt_rock_upd, cnt_scissor_upd, cnt_paper_upd;
    logic [CNT_W-1:0]   cnt_target;
    logic               cnt_halve;
    logic [7:0]         lfsr, lfsr_nxt;
    logic [1:0]         prediction;
    logic [1:0]         counter_move;
    logic               user_wins, comp_wins;

    logic               draw_req_nxt, draw_player_nxt, busy_nxt;
    logic [1:0]         draw_choice_nxt, comp_choice_nxt, result_nxt;
    logic [SCORE_W-1:0] user_score_nxt, comp_score_nxt;

    // Most frequent past move; rock > scissor > paper on a two-way tie, LFSR on a three-way tie
    always_comb begin
        prediction = MV_ROCK;
        if (cnt_rock == cnt_scissor && cnt_scissor == cnt_paper) begin
            prediction = (lfsr[1:0] == MV_INVALID) ? MV_ROCK : lfsr[1:0];
        end else if (cnt_rock >= cnt_scissor && cnt_rock >= cnt_paper) begin
            prediction = MV_ROCK;
        end else if (cnt_scissor >= cnt_paper) begin
            prediction = MV_SCISSOR;
        end else begin
            prediction = MV_PAPER;
        end

        case (prediction)
            MV_ROCK:    counter_move = MV_PAPER;
            MV_SCISSOR: counter_move = MV_ROCK;
            default:    counter_move = MV_SCISSOR;
        endcase
    end

    // Frequency update: halve everything when the target would overflow, then bump the target
    always_comb begin
        case (user_move)
            MV_SCISSOR: cnt_target = cnt_scissor;
            MV_PAPER:   cnt_target = cnt_paper;
            default:    cnt_target = cnt_rock;
        endcase
        cnt_halve       = (cnt_target == CNT_MAX);
        cnt_rock_upd    = cnt_halve ? (cnt_rock >> 1)    : cnt_rock;
        cnt_scissor_upd = cnt_halve ? (cnt_scissor >> 1) : cnt_scissor;
        cnt_paper_upd   = cnt_halve ? (cnt_paper >> 1)   : cnt_paper;
        case (user_move)
            MV_SCISSOR: cnt_scissor_upd = cnt_scissor_upd + CNT_W'(1);
            MV_PAPER:   cnt_paper_upd   = cnt_paper_upd + CNT_W'(1);
            default:    cnt_rock_upd    = cnt_rock_upd + CNT_W'(1);
        endcase
    end

    always_comb begin
        user_wins = (user_move == MV_ROCK    && comp_choice == MV_SCISSOR) ||
                    (user_move == MV_SCISSOR && comp_choice == MV_PAPER)   ||
                    (user_move == MV_PAPER   && comp_choice == MV_ROCK);
        comp_wins = !user_wins && (user_move != comp_choice);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        user_move_nxt   = user_move;
        cnt_rock_nxt    = cnt_rock;
        cnt_scissor_nxt = cnt_scissor;
        cnt_paper_nxt   = cnt_paper;
        lfsr_nxt        = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        draw_player_nxt = draw_player;
        draw_choice_nxt = draw_choice;
        comp_choice_nxt = comp_choice;
        result_nxt      = result;
        user_score_nxt  = user_score;
        comp_score_nxt  = comp_score;

        case (state)
            S_IDLE: begin
                if (go && user_choice != MV_INVALID) begin
                    user_move_nxt = user_choice;
                    state_nxt     = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                comp_choice_nxt = counter_move;
                cnt_rock_nxt    = cnt_rock_upd;
                cnt_scissor_nxt = cnt_scissor_upd;
                cnt_paper_nxt   = cnt_paper_upd;
                draw_player_nxt = 1'b0;
                draw_choice_nxt = user_move;
                state_nxt       = S_DRAW_U;
            end
            S_DRAW_U: begin
                if (draw_done) state_nxt = S_GAP;
            end
            S_GAP: begin
                draw_player_nxt = 1'b1;
                draw_choice_nxt = comp_choice;
                state_nxt       = S_DRAW_C;
            end
            S_DRAW_C: begin
                if (draw_done) state_nxt = S_SCORE;
            end
            S_SCORE: begin
                if (user_wins) begin
                    result_nxt = RES_USER;
                    if (user_score != SCORE_MAX) user_score_nxt = user_score + SCORE_W'(1);
                end else if (comp_wins) begin
                    result_nxt = RES_COMP;
                    if (comp_score != SCORE_MAX) comp_score_nxt = comp_score + SCORE_W'(1);
                end else begin
                    result_nxt = RES_TIE;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        draw_req_nxt = (state_nxt == S_DRAW_U) || (state_nxt == S_DRAW_C);
        busy_nxt     = (state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            user_move   <= MV_ROCK;
            cnt_rock    <= '0;
            cnt_scissor <= '0;
            cnt_paper   <= '0;
            lfsr        <= LFSR_SEED;
            draw_req    <= 1'b0;
            draw_player <= 1'b0;
            draw_choice <= 2'b00;
            comp_choice <= 2'b00;
            result      <= RES_TIE;
            user_score  <= '0;
            comp_score  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            user_move   <= user_move_nxt;
            cnt_rock    <= cnt_rock_nxt;
            cnt_scissor <= cnt_scissor_nxt;
            cnt_paper   <= cnt_paper_nxt;
            lfsr        <= lfsr_nxt;
            draw_req    <= draw_req_nxt;
            draw_player <= draw_player_nxt;
            draw_choice <= draw_choice_nxt;
            comp_choice <= comp_choice_nxt;
            result      <= result_nxt;
            user_score  <= user_score_nxt;
            comp_score  <= comp_score_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule
